// File: rtl/matmul_2x2_stream_drv.sv
// ---------------------------------------------------------------------------
// matmul_2x2_stream_drv
//
// Stream-side driver for the 2x2 matrix-multiply core. It collects an 8-beat
// input frame (A00,A01,A10,A11,B00,B01,B10,B11) from an AXI-Stream slave. It
// then pulses core_start, waits for core_done and returns C00,C01,C10,C11 on an
// AXI-Stream master with m_tlast on the fourth beat.
//
// Optional feature (compile-time macro MATMUL_DRV_TIMEOUT_EN):
//   When defined, a watchdog counts cycles spent in WAIT. After TIMEOUT_CYC
//   cycles without core_done, it sets err_frame, loads C with zeros and sends
//   the (zero) result so the output frame is still closed with m_tlast.
//   When undefined, WAIT holds until core_done and TIMEOUT_CYC is unused.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   input element stream (signed DATA_W)
//   core_start        one-cycle start pulse to the core
//   core_a, core_b    A/B matrices, flat: element (r,c) at index r*2+c,
//                     bits [(r*2+c)*DATA_W +: DATA_W]
//   core_c            C matrix from the core, same packing with ACC_W
//   core_done         core result valid (only honoured in WAIT)
//   m_tdata/m_tvalid/m_tready/m_tlast   output C stream (signed ACC_W)
//   busy              high in any state other than LOAD
//   err_frame         sticky framing/timeout error, cleared only by rst
//
// Handshake semantics (both streams): a beat transfers on a rising edge where
// valid and ready are both high. Once m_tvalid is raised, m_tdata and m_tlast
// are held until that transfer happens; m_tvalid never drops mid-beat.
// ---------------------------------------------------------------------------
module matmul_2x2_stream_drv #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 32,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic                s_tlast,
    output logic                core_start,
    output logic [4*DATA_W-1:0] core_a,
    output logic [4*DATA_W-1:0] core_b,
    input  logic [4*ACC_W-1:0]  core_c,
    input  logic                core_done,
    output logic [ACC_W-1:0]    m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic                m_tlast,
    output logic                busy,
    output logic                err_frame
);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;     // input beat counter 0..7
    logic [1:0]          idx_q, idx_d;     // output beat index 0..3
    // Beats 0..3 (A) land in the low half, beats 4..7 (B) in the high half,
    // so the beat counter directly addresses the element slot.
    logic [8*DATA_W-1:0] ab_q, ab_d;
    logic [4*ACC_W-1:0]  c_q, c_d;
    logic                err_q, err_d;

`ifdef MATMUL_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
`endif

    assign core_a    = ab_q[4*DATA_W-1:0];
    assign core_b    = ab_q[8*DATA_W-1:4*DATA_W];
    assign err_frame = err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ab_d       = ab_q;
        c_d        = c_q;
        err_d      = err_q;
        s_tready   = 1'b0;
        core_start = 1'b0;
        m_tvalid   = 1'b0;
        m_tdata    = '0;
        m_tlast    = 1'b0;
        busy       = 1'b1;
`ifdef MATMUL_DRV_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif

        case (state_q)
            ST_LOAD: begin
                s_tready = 1'b1;
                busy     = 1'b0;
                if (s_tvalid) begin
                    ab_d[int'(cnt_q)*DATA_W +: DATA_W] = s_tdata;
                    if (cnt_q == 3'd7) begin
                        // A missing tlast on the final beat is flagged, but
                        // the frame is complete, so it still runs.
                        if (!s_tlast) begin
                            err_d = 1'b1;
                        end
                        cnt_d   = 3'd0;
                        state_d = ST_START;
                    end else if (s_tlast) begin
                        // Short frame: drop what was collected and resync.
                        err_d = 1'b1;
                        cnt_d = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_START: begin
                core_start = 1'b1;
                state_d    = ST_WAIT;
`ifdef MATMUL_DRV_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end

            ST_WAIT: begin
                if (core_done) begin
                    c_d     = core_c;
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end
`ifdef MATMUL_DRV_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    // The final allowed WAIT cycle passed with no result.
                    err_d   = 1'b1;
                    c_d     = '0;
                    idx_d   = 2'd0;
                    state_d = ST_SEND;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end

            ST_SEND: begin
                m_tvalid = 1'b1;
                m_tdata  = c_q[int'(idx_q)*ACC_W +: ACC_W];
                m_tlast  = (idx_q == 2'd3);
                if (m_tready) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        cnt_d   = 3'd0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            ab_q    <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
`ifdef MATMUL_DRV_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ab_q    <= ab_d;
            c_q     <= c_d;
            err_q   <= err_d;
`ifdef MATMUL_DRV_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_matmul_2x2_stream_drv.sv
// ---------------------------------------------------------------------------
// tb_matmul_2x2_stream_drv
//
// Directed bench for matmul_2x2_stream_drv. The bench stands in for the core:
// after core_start it multiplies the A/B matrices it sees on core_a/core_b and
// presents the product on core_c before pulsing core_done. Every streamed
// result is compared against hand-computed constants.
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_matmul_2x2_stream_drv;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int TMO    = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic                s_tlast;
    logic                core_start;
    logic [4*DATA_W-1:0] core_a;
    logic [4*DATA_W-1:0] core_b;
    logic [4*ACC_W-1:0]  core_c;
    logic                core_done;
    logic [ACC_W-1:0]    m_tdata;
    logic                m_tvalid;
    logic                m_tready;
    logic                m_tlast;
    logic                busy;
    logic                err_frame;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int start_cnt = 0;

    matmul_2x2_stream_drv #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .s_tlast    (s_tlast),
        .core_start (core_start),
        .core_a     (core_a),
        .core_b     (core_b),
        .core_c     (core_c),
        .core_done  (core_done),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .err_frame  (err_frame)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start) start_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Reference product of the matrices the core is handed.
    function automatic logic [4*ACC_W-1:0] calc_c(input logic [31:0] a, input logic [31:0] b);
        logic [4*ACC_W-1:0] res;
        logic signed [7:0]  x0, x1, y0, y1;
        res = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                x0 = a[(r*2+0)*8 +: 8];
                x1 = a[(r*2+1)*8 +: 8];
                y0 = b[(0*2+c)*8 +: 8];
                y1 = b[(1*2+c)*8 +: 8];
                res[(r*2+c)*32 +: 32] = 32'(int'(x0) * int'(y0) + int'(x1) * int'(y1));
            end
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    // Drives nbeats beats, tlast on beat tlast_at; returns at the falling edge
    // of the cycle after the last beat was accepted.
    task automatic send_frame(input int el[8], input int tlast_at, input int nbeats);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            s_tvalid = 1'b1;
            s_tdata  = el[i][7:0];
            s_tlast  = (i == tlast_at);
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
    endtask

    // Collects four output beats, checking every valid cycle (stalled ones too).
    task automatic recv(input string tag, input int exp[4], input bit bp);
        int k;
        int cyc;
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 40) begin
            m_tready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd1);
            if (m_tvalid) begin
                check($sformatf("%s_m_tdata%0d", tag, k), m_tdata, exp[k]);
                check($sformatf("%s_m_tlast%0d", tag, k), 32'(m_tlast), 32'(k == 3));
                if (m_tready) k++;
            end
            cyc++;
            @(negedge clk);
        end
        m_tready = 1'b1;
        check({tag, "_beats"}, 32'(k), 32'd4);
        check({tag, "_idle_m_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_s_tready"}, 32'(s_tready), 32'd1);
    endtask

    // Full frame: load, check start pulse and A/B, emulate core, check output.
    task automatic exec(input string tag, input int el[8], input int exp[4], input bit bp);
        int          sc;
        logic [31:0] ea, eb;
        sc = start_cnt;
        for (int i = 0; i < 4; i++) begin
            ea[i*8 +: 8] = el[i][7:0];
            eb[i*8 +: 8] = el[i+4][7:0];
        end
        send_frame(el, 7, 8);
        check({tag, "_core_start"}, 32'(core_start), 32'd1);
        check({tag, "_start_s_tready"}, 32'(s_tready), 32'd0);
        check({tag, "_start_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_start_once"}, 32'(core_start), 32'd0);
        check({tag, "_core_a"}, core_a, ea);
        check({tag, "_core_b"}, core_b, eb);
        core_c = calc_c(core_a, core_b);
        repeat (2) @(negedge clk);
        check({tag, "_wait_m_tvalid"}, 32'(m_tvalid), 32'd0);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_c    = {4{32'hA5A5_5A5A}};   // result must already be latched
        recv(tag, exp, bp);
        check({tag, "_start_count"}, 32'(start_cnt - sc), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int el[8];
        int ex[4];
        int sc;
        int n;

        rst       = 1'b1;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        core_c    = '0;
        core_done = 1'b0;
        m_tready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_s_tready", 32'(s_tready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_err_frame", 32'(err_frame), 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);

        // Basic
        el = '{1, 2, 3, 4, 5, 6, 7, 8};
        ex = '{19, 22, 43, 50};
        exec("basic", el, ex, 1'b0);
        check("basic_err_frame", 32'(err_frame), 32'd0);

        // Signed extremes
        el = '{-128, -128, 127, 0, -128, 1, -128, -1};
        ex = '{32768, 0, -16256, 127};
        exec("signed", el, ex, 1'b0);

        // Backpressure: identity * B = B
        el = '{1, 0, 0, 1, -3, 4, 5, -6};
        ex = '{-3, 4, 5, -6};
        exec("bp", el, ex, 1'b1);
        check("bp_err_frame", 32'(err_frame), 32'd0);

        // Early tlast on beat 3, then a good frame
        sc = start_cnt;
        el = '{9, 9, 9, 9, 0, 0, 0, 0};
        send_frame(el, 3, 4);
        check("early_err_frame", 32'(err_frame), 32'd1);
        check("early_busy", 32'(busy), 32'd0);
        check("early_s_tready", 32'(s_tready), 32'd1);
        repeat (3) @(negedge clk);
        check("early_no_start", 32'(start_cnt - sc), 32'd0);
        el = '{2, 0, 0, 2, 1, -1, 3, 4};
        ex = '{2, -2, 6, 8};
        exec("after_early", el, ex, 1'b0);
        check("after_early_err_sticky", 32'(err_frame), 32'd1);

        // Reset while waiting for the core
        el = '{1, 2, 3, 4, 5, 6, 7, 8};
        send_frame(el, 7, 8);
        check("rstwait_core_start", 32'(core_start), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstwait_busy", 32'(busy), 32'd0);
        check("rstwait_s_tready", 32'(s_tready), 32'd1);
        check("rstwait_err_cleared", 32'(err_frame), 32'd0);
        check("rstwait_core_a", core_a, 32'd0);
        core_c    = calc_c(32'h0403_0201, 32'h0807_0605);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rstwait_no_m_tvalid", 32'(m_tvalid), 32'd0);
            check("rstwait_idle_busy", 32'(busy), 32'd0);
            @(negedge clk);
        end

`ifdef MATMUL_DRV_TIMEOUT_EN
        // Watchdog: core never answers
        el = '{1, 2, 3, 4, 5, 6, 7, 8};
        core_c = {4{32'h1234_5678}};
        send_frame(el, 7, 8);
        check("tmo_core_start", 32'(core_start), 32'd1);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (m_tvalid) break;
            n++;
        end
        check("tmo_wait_cycles", 32'(n), 32'(TMO));
        check("tmo_err_frame", 32'(err_frame), 32'd1);
        ex = '{0, 0, 0, 0};
        recv("tmo", ex, 1'b0);
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/matmul_2x2_stream_drv.md
Name: matmul_2x2_stream_drv

Overview:
- Stream-side driver for the 2x2 matrix-multiply core (start / A / B in, C / done out); it is the initiator that test stimulus currently emulates.
- Collects A and B elements from an AXI-Stream slave, launches the core, and waits for done.
- Returns the four C results on an AXI-Stream master.
- Sits between the accelerator's DMA/stream fabric and the matmul core.

Parameters:
- DATA_W, 8, signed element width of A and B.
- ACC_W, 32, signed width of C elements and of the output stream.
- TIMEOUT_CYC, 256, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_tdata  in  DATA_W  input element, signed.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat ready.
- s_tlast  in  1  marks the final beat of an input frame.
- core_start  out  1  one-cycle start pulse to the core.
- core_a  out  2x2 x DATA_W  A matrix to the core, signed.
- core_b  out  2x2 x DATA_W  B matrix to the core, signed.
- core_c  in  2x2 x ACC_W  C matrix from the core, signed.
- core_done  in  1  core result valid.
- m_tdata  out  ACC_W  output C element.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  output beat ready.
- m_tlast  out  1  marks the final output beat.
- busy  out  1  high in any state other than LOAD.
- err_frame  out  1  sticky framing error; cleared only by rst.

Behaviour:
- Reset (synchronous): state=LOAD, beat counter=0, A/B/C registers=0. All outputs 0 except s_tready=1.
- Input frame is 8 beats: A00,A01,A10,A11, then B00,B01,B10,B11 (row-major). s_tlast is expected on beat 7 only.
- LOAD:
  - s_tready=1; a beat is accepted when s_tvalid & s_tready.
  - The element is written into the A/B register selected by the beat counter, and the counter increments.
  - s_tlast on beats 0..6: set err_frame, discard the partial frame, counter=0, stay in LOAD.
  - Beat 7 without s_tlast: set err_frame, but the frame is still executed.
  - Accepting beat 7 moves the state to START on the next edge.
- START: core_start=1 for exactly one cycle, s_tready=0, then WAIT.
- A/B registers drive core_a/core_b continuously and are stable from START until the next LOAD write.
- WAIT: when core_done=1, capture core_c into the C register on that edge and go to SEND. core_done in any other state is ignored.
- SEND:
  - m_tvalid=1; m_tdata=C[idx], with idx 0..3 selecting C00,C01,C10,C11.
  - m_tlast=1 when idx==3.
  - idx advances on m_tvalid & m_tready.
  - m_tdata and m_tlast are held stable while m_tvalid & !m_tready.
  - After the idx==3 handshake: m_tvalid=0, state=LOAD, counters=0.
- Latency:
  - Last input beat accepted at edge N.
  - core_start high during cycle N+1.
  - First m_tvalid in the cycle after core_done is sampled.
- Arithmetic: no arithmetic in this block. C is passed through at full ACC_W, sign preserved. A/B are stored unmodified.
- Back-to-back frames: s_tready is low during START/WAIT/SEND. The next frame may begin the cycle after the final output handshake.
- rst mid-operation: returns to LOAD on that edge. m_tvalid and core_start are deasserted. Any in-flight core result is ignored, including a later core_done (not in WAIT).

Optional Feature:
- Macro: MATMUL_DRV_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If core_done has not arrived after TIMEOUT_CYC cycles in WAIT, set err_frame and load C with all zeros.
  - Go to SEND so the downstream frame is still terminated with m_tlast.
- When undefined: no counter; WAIT holds indefinitely and TIMEOUT_CYC is unused.

Test Plan:
- Basic: A={{1,2},{3,4}}, B={{5,6},{7,8}}, s_tlast on beat 7, m_tready=1 -> exactly one core_start pulse; output 19,22,43,50 with m_tlast only on 50; err_frame=0.
- Signed extremes: A={{-128,-128},{127,0}}, B={{-128,1},{-128,-1}} -> output 32768, 0, -16256, 127.
- Backpressure: m_tready toggled 1-0-0-1 pattern during SEND -> m_tdata/m_tlast stable while stalled; all 4 beats delivered in order, none duplicated.
- Early tlast: s_tlast on beat 3 -> err_frame=1, no core_start; a following valid 8-beat frame is processed correctly.
- Reset in WAIT: assert rst for 1 cycle before core_done, then pulse core_done -> no m_tvalid; busy=0; s_tready=1.
- Timeout (MATMUL_DRV_TIMEOUT_EN, TIMEOUT_CYC=16): core_done held 0 -> after 16 WAIT cycles err_frame=1; output 0,0,0,0 with m_tlast on the 4th beat.
